// File: rtl/fp_align.sv
// fp_align: multi-cycle operand alignment ahead of the binary32 adder core.
// The stage orders two operands by magnitude, then shifts the smaller
// significand right one bit per cycle. Discarded bits collect in a sticky bit.
// The result is held stable in DONE until the downstream consumes it.
module fp_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_big_sign,
    output logic                  out_sub,
    output logic [7:0]            out_exp,
    output logic [26:0]           out_big_man,
    output logic [26:0]           out_small_man,
    output logic                  out_special
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [4:0] MAX_SHIFT = 5'd27;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        big_sign_q;
    logic        sub_q;
    logic [7:0]  exp_q;
    logic [26:0] big_man_q;
    logic [26:0] small_man_q;
    logic        special_q;

    // Fields of the incoming operands. B's sign already has sel folded in.
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        sign_a, sign_b_eff;
    logic        a_is_big;
    logic [7:0]  eff_big, eff_small, exp_diff;

    // Load values captured on accept.
    logic        big_sign_d;
    logic        sub_d;
    logic [7:0]  exp_d;
    logic [26:0] big_man_d;
    logic [26:0] small_man_d;
    logic        special_d;
    logic [4:0]  shift_d;

    // Unpack, order by magnitude and compute the shift count for a new operand pair.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        exp_a       = a[30:23];
        exp_b       = b[30:23];
        frac_a      = a[22:0];
        frac_b      = b[22:0];
        sign_a      = a[31];
        sign_b_eff  = b[31] ^ sel;
        a_is_big    = (a[30:0] >= b[30:0]);
        special_d   = (exp_a == 8'hFF) || (exp_b == 8'hFF);
        sub_d       = a[31] ^ b[31] ^ sel;
        big_sign_d  = sign_b_eff;
        exp_d       = exp_b;
        big_man_d   = {(exp_b != 8'd0), frac_b, 3'b000};
        small_man_d = {(exp_a != 8'd0), frac_a, 3'b000};
        eff_big     = (exp_b == 8'd0) ? 8'd1 : exp_b;
        eff_small   = (exp_a == 8'd0) ? 8'd1 : exp_a;
        if (a_is_big) begin
            big_sign_d  = sign_a;
            exp_d       = exp_a;
            big_man_d   = {(exp_a != 8'd0), frac_a, 3'b000};
            small_man_d = {(exp_b != 8'd0), frac_b, 3'b000};
            eff_big     = (exp_a == 8'd0) ? 8'd1 : exp_a;
            eff_small   = (exp_b == 8'd0) ? 8'd1 : exp_b;
        end
        // The ordering on {exp, frac} makes eff_big >= eff_small, because a zero exponent maps to 1.
        exp_diff = eff_big - eff_small;
        if (special_d) begin
            shift_d = 5'd0;
        end else if (exp_diff > {3'b000, MAX_SHIFT}) begin
            shift_d = MAX_SHIFT;
        end else begin
            shift_d = exp_diff[4:0];
        end
    end

    // Control FSM and datapath registers: load on accept, shift in SHIFT, hold in DONE.
    // NOTE: sequential state uses non-blocking assignments so that all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            big_sign_q  <= 1'b0;
            sub_q       <= 1'b0;
            exp_q       <= 8'd0;
            big_man_q   <= 27'd0;
            small_man_q <= 27'd0;
            special_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        big_sign_q  <= big_sign_d;
                        sub_q       <= sub_d;
                        exp_q       <= exp_d;
                        big_man_q   <= big_man_d;
                        small_man_q <= small_man_d;
                        special_q   <= special_d;
                        cnt_q       <= shift_d;
                        state_q     <= (shift_d != 5'd0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    // The bit shifted out merges into bit 0, so the sticky bit never clears.
                    small_man_q <= {1'b0, small_man_q[26:2], small_man_q[1] | small_man_q[0]};
                    cnt_q       <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The handshake flags come straight from the state register and carry no combinational input path.
    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_big_sign  = big_sign_q;
    assign out_sub       = sub_q;
    assign out_exp       = exp_q;
    assign out_big_man   = big_man_q;
    assign out_small_man = small_man_q;
    assign out_special   = special_q;

endmodule

// File: tb/tb_fp_align.sv
// tb_fp_align: directed and randomized checks of fp_align against a
// behavioural alignment model that uses plain integer arithmetic.
module tb_fp_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic        out_big_sign;
    logic        out_sub;
    logic [7:0]  out_exp;
    logic [26:0] out_big_man;
    logic [26:0] out_small_man;
    logic        out_special;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit      big_sign;
        bit      sub;
        bit      special;
        int      exp_v;
        longint  big_man;
        longint  small_man;
        int      n;
    } expect_t;

    expect_t cur_e;

    fp_align #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .sel           (sel),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_big_sign  (out_big_sign),
        .out_sub       (out_sub),
        .out_exp       (out_exp),
        .out_big_man   (out_big_man),
        .out_small_man (out_small_man),
        .out_special   (out_special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: the magnitude order, the shift distance and the exact sticky right shift, in integer arithmetic.
    function automatic expect_t model(input bit [31:0] ta, input bit [31:0] tb_v, input bit ts);
        expect_t r;
        int ea, eb, fa, fb, e_big, e_small, f_big, f_small, eff_big, eff_small, d;
        bit a_big;
        longint loaded, lost;
        ea = int'(ta[30:23]);
        eb = int'(tb_v[30:23]);
        fa = int'(ta[22:0]);
        fb = int'(tb_v[22:0]);
        a_big = (ta[30:0] >= tb_v[30:0]);
        r.special = (ea == 255) || (eb == 255);
        r.sub = ta[31] ^ tb_v[31] ^ ts;
        if (a_big) begin
            e_big = ea; f_big = fa; e_small = eb; f_small = fb;
            r.big_sign = ta[31];
        end else begin
            e_big = eb; f_big = fb; e_small = ea; f_small = fa;
            r.big_sign = tb_v[31] ^ ts;
        end
        r.exp_v   = e_big;
        eff_big   = (e_big == 0) ? 1 : e_big;
        eff_small = (e_small == 0) ? 1 : e_small;
        d = eff_big - eff_small;
        r.n = r.special ? 0 : ((d > 27) ? 27 : d);
        r.big_man = (longint'((e_big != 0) ? 1 : 0) * 8388608 + longint'(f_big)) * 8;
        loaded    = (longint'((e_small != 0) ? 1 : 0) * 8388608 + longint'(f_small)) * 8;
        lost      = loaded % (64'sd1 <<< r.n);
        r.small_man = (loaded >>> r.n) | ((lost != 0) ? 64'sd1 : 64'sd0);
        return r;
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".valid"},     longint'(out_valid), 1);
        check({tag, ".exp"},       longint'(out_exp), longint'(cur_e.exp_v));
        check({tag, ".big_man"},   longint'(out_big_man), cur_e.big_man);
        check({tag, ".small_man"}, longint'(out_small_man), cur_e.small_man);
        check({tag, ".big_sign"},  longint'(out_big_sign), longint'(cur_e.big_sign));
        check({tag, ".sub"},       longint'(out_sub), longint'(cur_e.sub));
        check({tag, ".special"},   longint'(out_special), longint'(cur_e.special));
    endtask

    // Present the operands, wait for acceptance, then count edges until out_valid is high.
    task automatic start_op(input string tag, input bit [31:0] ta, input bit [31:0] tb_v, input bit ts);
        int lat;
        int guard;
        cur_e = model(ta, tb_v, ts);
        a = ta; b = tb_v; sel = ts; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sel = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, ".latency"}, longint'(lat), longint'(cur_e.n));
        check_outs(tag);
    endtask

    // Hold back out_ready while new operands are offered, then consume the result.
    task automatic finish_op(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i % 2 == 0);
            a = $urandom; b = $urandom; sel = 1'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold_ready"}, longint'(in_ready), 0);
            check_outs({tag, ".hold"});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".idle_ready"}, longint'(in_ready), 1);
        check({tag, ".idle_valid"}, longint'(out_valid), 0);
    endtask

    function automatic bit [31:0] rand_operand(input int base_exp);
        int e;
        e = base_exp + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        if ($urandom_range(0, 15) == 0) e = 0;
        if ($urandom_range(0, 31) == 0) e = 255;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        #12;
        check("reset.in_ready",  longint'(in_ready), 1);
        check("reset.out_valid", longint'(out_valid), 0);
        check("reset.small_man", longint'(out_small_man), 0);
        check("reset.exp",       longint'(out_exp), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op("large_gap", 32'h0FC20FC2, 32'h2FA88A10, 1'b0);
        check("large_gap.exp_lit",   longint'(out_exp), 64'h5F);
        check("large_gap.small_lit", longint'(out_small_man), 1);
        check("large_gap.sub_lit",   longint'(out_sub), 0);
        finish_op("large_gap", 0);

        start_op("mod_gap", 32'h4FF00800, 32'h57900000, 1'b0);
        check("mod_gap.exp_lit",   longint'(out_exp), 64'hAF);
        check("mod_gap.big_lit",   longint'(out_big_man), 64'h4800000);
        check("mod_gap.small_lit", longint'(out_small_man), 64'h781);
        finish_op("mod_gap", 0);

        start_op("equal_sub", 32'h3F800000, 32'h3F800000, 1'b1);
        check("equal_sub.big_lit",   longint'(out_big_man), 64'h4000000);
        check("equal_sub.small_lit", longint'(out_small_man), 64'h4000000);
        check("equal_sub.sub_lit",   longint'(out_sub), 1);
        finish_op("equal_sub", 0);

        start_op("backpressure", 32'h4FF00800, 32'h57900000, 1'b0);
        finish_op("backpressure", 5);

        // Start a large-gap operation, then reset it asynchronously partway through SHIFT.
        a = 32'h0FC20FC2; b = 32'h2FA88A10; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset.out_valid", longint'(out_valid), 0);
        check("mid_reset.in_ready",  longint'(in_ready), 1);
        check("mid_reset.big_man",   longint'(out_big_man), 0);
        check("mid_reset.small_man", longint'(out_small_man), 0);
        check("mid_reset.exp",       longint'(out_exp), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start_op("after_reset", 32'h4FF00800, 32'h57900000, 1'b0);
        finish_op("after_reset", 0);

        start_op("special", 32'h7F800000, 32'h3F800000, 1'b0);
        check("special.flag_lit", longint'(out_special), 1);
        check("special.exp_lit",  longint'(out_exp), 64'hFF);
        finish_op("special", 1);

        for (int i = 0; i < 40; i++) begin
            int base;
            base = int'($urandom_range(1, 250));
            start_op($sformatf("rand%0d", i), rand_operand(base), rand_operand(base), 1'($urandom));
            finish_op($sformatf("rand%0d", i), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
